// File: rtl/otter_fetch_unit.sv
// OTTER fetch unit: owns pc and ir, fetches one instruction per request over a
// request/response instruction-memory port, and selects the next pc on writeback.
module otter_fetch_unit #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        fetch_start,
  input  logic        pc_write,
  input  logic [2:0]  pc_source,
  input  logic [31:0] jalr_pc,
  input  logic [31:0] branch_pc,
  input  logic [31:0] jal_pc,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] ir,
  output logic        fetch_done,
  output logic        fetch_err,
  output logic        misalign,
  output logic        busy
);

  localparam logic [31:0] Nop     = 32'h0000_0013;
  localparam logic [7:0]  CntLast = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        ok_q, ok_d;          // DONE reports success (1) or timeout (0)
  logic        misalign_q, misalign_d;
  logic [31:0] target;
  logic        target_valid;

  assign pc_plus4 = pc_q + 32'd4;

  // Next-pc candidate; sources 6/7 mean hold.
  always_comb begin
    target       = pc_plus4;
    target_valid = 1'b1;
    case (pc_source)
      3'd0:    target = pc_plus4;
      3'd1:    target = jalr_pc;
      3'd2:    target = branch_pc;
      3'd3:    target = jal_pc;
      3'd4:    target = mtvec;
      3'd5:    target = mepc;
      default: target_valid = 1'b0;
    endcase
  end

  // Fetch FSM next state, pc/ir update and timeout counting.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    cnt_d      = cnt_q;
    ok_d       = ok_q;
    misalign_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pc_write && target_valid) begin
          pc_d       = {target[31:2], 2'b00};
          misalign_d = |target[1:0];
        end
        if (fetch_start) state_d = StReq;
      end
      StReq: begin
        if (imem_ready) begin
          state_d = StWait;
          cnt_d   = 8'd0;
        end
      end
      StWait: begin
        if (imem_rvalid) begin
          ir_d    = imem_rdata;
          ok_d    = 1'b1;
          state_d = StDone;
        end else if (cnt_q == CntLast) begin
          ir_d    = Nop;
          ok_d    = 1'b0;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= StIdle;
      pc_q       <= RESET_VEC;
      ir_q       <= Nop;
      cnt_q      <= 8'd0;
      ok_q       <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      cnt_q      <= cnt_d;
      ok_q       <= ok_d;
      misalign_q <= misalign_d;
    end
  end

  assign pc         = pc_q;
  assign ir         = ir_q;
  assign imem_addr  = pc_q;
  assign imem_req   = (state_q == StReq);
  assign busy       = (state_q != StIdle);
  assign fetch_done = (state_q == StDone) && ok_q;
  assign fetch_err  = (state_q == StDone) && !ok_q;
  assign misalign   = misalign_q;

endmodule

// File: tb/tb_otter_fetch_unit.sv
// Directed bench for otter_fetch_unit with hand-computed expectations.
module tb_otter_fetch_unit;

  localparam logic [31:0] ResetVec = 32'h0000_0100;
  localparam logic [31:0] Nop      = 32'h0000_0013;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        fetch_start = 1'b0;
  logic        pc_write = 1'b0;
  logic [2:0]  pc_source = 3'd0;
  logic [31:0] jalr_pc = '0, branch_pc = '0, jal_pc = '0, mtvec = '0, mepc = '0;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        imem_req;
  logic [31:0] imem_addr, pc, pc_plus4, ir;
  logic        fetch_done, fetch_err, misalign, busy;

  int checks = 0;
  int errors = 0;

  otter_fetch_unit #(
    .RESET_VEC(ResetVec),
    .TIMEOUT  (16)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .fetch_start(fetch_start),
    .pc_write   (pc_write),
    .pc_source  (pc_source),
    .jalr_pc    (jalr_pc),
    .branch_pc  (branch_pc),
    .jal_pc     (jal_pc),
    .mtvec      (mtvec),
    .mepc       (mepc),
    .imem_ready (imem_ready),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .ir         (ir),
    .fetch_done (fetch_done),
    .fetch_err  (fetch_err),
    .misalign   (misalign),
    .busy       (busy)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle before sampling.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    // Reset
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("rst_pc", pc, ResetVec);
    check("rst_ir", ir, Nop);
    check("rst_busy", 32'(busy), 0);
    check("rst_req", 32'(imem_req), 0);
    check("rst_done", 32'(fetch_done), 0);
    check("rst_err", 32'(fetch_err), 0);
    check("rst_misalign", 32'(misalign), 0);
    check("rst_pc4", pc_plus4, 32'h104);

    // Fetch with immediate ready and rvalid one cycle after accept
    fetch_start = 1'b1;
    imem_ready  = 1'b1;
    tick();
    fetch_start = 1'b0;
    check("f1_req", 32'(imem_req), 1);
    check("f1_addr", imem_addr, 32'h100);
    check("f1_busy", 32'(busy), 1);
    check("f1_done_c1", 32'(fetch_done), 0);
    tick();
    check("f1_wait_req", 32'(imem_req), 0);
    check("f1_done_c2", 32'(fetch_done), 0);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0050_0093;
    tick();
    imem_rvalid = 1'b0;
    check("f1_done_c3", 32'(fetch_done), 1);
    check("f1_err", 32'(fetch_err), 0);
    check("f1_ir", ir, 32'h0050_0093);
    tick();
    check("f1_done_c4", 32'(fetch_done), 0);
    check("f1_idle", 32'(busy), 0);
    check("f1_ir_hold", ir, 32'h0050_0093);

    // PC writes in IDLE
    pc_write = 1'b1; pc_source = 3'd3; jal_pc = 32'h0000_0206;
    tick();
    pc_write = 1'b0;
    check("jal_pc", pc, 32'h204);
    check("jal_misalign", 32'(misalign), 1);
    tick();
    check("jal_misalign_clr", 32'(misalign), 0);
    pc_write = 1'b1; pc_source = 3'd2; branch_pc = 32'h0000_0300;
    tick();
    pc_write = 1'b0;
    check("br_pc", pc, 32'h300);
    check("br_misalign", 32'(misalign), 0);
    pc_write = 1'b1; pc_source = 3'd6; mepc = 32'h0000_0045;
    tick();
    pc_write = 1'b0;
    check("hold_pc", pc, 32'h300);
    check("hold_misalign", 32'(misalign), 0);

    // Stalled request, ignored commands, then timeout
    imem_ready  = 1'b0;
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        fetch_start = 1'b1; pc_write = 1'b1; pc_source = 3'd1; jalr_pc = 32'h0000_0500;
      end else begin
        fetch_start = 1'b0; pc_write = 1'b0;
      end
      check("stall_req", 32'(imem_req), 1);
      check("stall_addr", imem_addr, 32'h300);
      tick();
    end
    fetch_start = 1'b0; pc_write = 1'b0;
    check("stall_pc", pc, 32'h300);
    check("stall_misalign", 32'(misalign), 0);
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    for (int i = 0; i < 15; i++) begin
      check("to_wait_err", 32'(fetch_err), 0);
      check("to_wait_busy", 32'(busy), 1);
      tick();
    end
    check("to_wait_last", 32'(fetch_err), 0);
    tick();
    check("to_err", 32'(fetch_err), 1);
    check("to_done", 32'(fetch_done), 0);
    check("to_ir", ir, Nop);
    tick();
    check("to_err_clr", 32'(fetch_err), 0);
    check("to_busy", 32'(busy), 0);
    check("to_pc", pc, 32'h300);

    // Wrap of pc+4 with simultaneous fetch_start
    pc_write = 1'b1; pc_source = 3'd4; mtvec = 32'hFFFF_FFFC;
    tick();
    check("mtvec_pc", pc, 32'hFFFF_FFFC);
    check("wrap_pc4", pc_plus4, 32'h0);
    pc_source = 3'd0; fetch_start = 1'b1;
    tick();
    pc_write = 1'b0; fetch_start = 1'b0;
    check("wrap_pc", pc, 32'h0);
    check("wrap_req", 32'(imem_req), 1);
    check("wrap_addr", imem_addr, 32'h0);
    check("wrap_misalign", 32'(misalign), 0);
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    check("wrap_wait", 32'(busy), 1);

    // Reset during WAIT, late rvalid ignored
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("mid_rst_pc", pc, ResetVec);
    check("mid_rst_busy", 32'(busy), 0);
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    check("late_done", 32'(fetch_done), 0);
    check("late_ir", ir, Nop);
    tick();
    imem_rvalid = 1'b0;
    check("late_done2", 32'(fetch_done), 0);
    check("late_busy", 32'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/otter_fetch_unit.md
Name: otter_fetch_unit

Overview:
Owns the OTTER program counter and instruction register, and drives the `pc`/`ir` pair consumed by the immediate/target value generator. On command from the control FSM it fetches one instruction over a request/response instruction-memory interface. On writeback it selects the next PC from pc+4, jalr, branch, jal, mtvec or mepc.

Parameters:
RESET_VEC, 32'h0000_0000, PC value loaded on reset
TIMEOUT, 16, max cycles in WAIT before aborting the fetch (range 2..255)

Ports:
CLK  in  1  system clock, all state updates on rising edge
RST  in  1  synchronous, active-high reset
fetch_start  in  1  control FSM request to fetch the instruction at pc
pc_write  in  1  load next PC selected by pc_source
pc_source  in  3  0 pc+4, 1 jalr_pc, 2 branch_pc, 3 jal_pc, 4 mtvec, 5 mepc, 6/7 hold
jalr_pc, branch_pc, jal_pc  in  32 each  targets from value generator
mtvec, mepc  in  32 each  trap vector / trap return address from CSR file
imem_ready  in  1  memory accepts request this cycle
imem_rvalid  in  1  read data valid
imem_rdata  in  32  instruction word
imem_req  out  1  request valid
imem_addr  out  32  request address (= pc)
pc  out  32  current PC
pc_plus4  out  32  pc + 4, combinational, wraps mod 2^32
ir  out  32  latched instruction
fetch_done  out  1  one-cycle pulse: ir updated
fetch_err  out  1  one-cycle pulse: timeout, ir loaded with NOP
misalign  out  1  one-cycle pulse: selected target had bits[1:0] != 0
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values (next edge with RST=1): pc=RESET_VEC, ir=32'h0000_0013 (NOP), state=IDLE. imem_req, fetch_done, fetch_err, misalign and busy are all 0. Timeout counter=0.
- RST takes priority over everything. Reset mid-fetch abandons the transaction. Any imem_rvalid arriving after reset is ignored because the FSM is in IDLE.
- FSM states:
  - IDLE: fetch_start=1 -> REQ.
  - REQ: imem_req=1, imem_addr=pc. imem_ready=1 -> WAIT with counter cleared. Otherwise stay in REQ and hold the request stable.
  - WAIT: imem_req=0. imem_rvalid is sampled only in WAIT, so minimum latency is 1 cycle after accept.
    - imem_rvalid=1: ir<=imem_rdata, fetch_done=1 in the following cycle (DONE state), then -> IDLE.
    - Counter reaches TIMEOUT-1 without rvalid: ir<=NOP, fetch_err=1 (DONE state), -> IDLE.
  - DONE: single cycle, pulses fetch_done or fetch_err, -> IDLE.
- Fetch latency: minimum 3 cycles from fetch_start to fetch_done (REQ, WAIT, DONE) when ready and rvalid arrive immediately.
- fetch_start outside IDLE is ignored. There is no queuing.
- PC update is accepted only in IDLE.
  - pc_write=1 with pc_source 0-5: pc<=target with bits[1:0] forced to 0.
  - misalign pulses in the next cycle if the raw target had bits[1:0] != 0.
  - pc_source 6/7: pc unchanged, no misalign.
  - pc_write outside IDLE is ignored.
- fetch_start and pc_write in the same IDLE cycle: pc updates on that edge, and REQ then presents the new pc on imem_addr.
- ir holds its value between fetches. pc never changes during REQ/WAIT/DONE.
- pc+4 from 32'hFFFF_FFFC wraps to 32'h0000_0000 with no flag.

Test Plan:
- Reset with RESET_VEC=32'h100, then fetch_start, ready=1, rvalid one cycle after accept with rdata=32'h00500093 -> imem_addr=32'h100 in REQ; ir=32'h00500093; fetch_done pulses exactly once, 3 cycles after start.
- In IDLE, pc_write=1, pc_source=3, jal_pc=32'h0000_0206 -> pc=32'h204, misalign pulses once. Repeat with pc_source=2, branch_pc=32'h300 -> pc=32'h300, no misalign.
- Hold imem_ready low for 5 cycles -> imem_req stays 1 with imem_addr stable. Assert fetch_start and pc_write during the wait -> both ignored, pc unchanged.
- TIMEOUT=16 and rvalid never asserted -> fetch_err pulses after 16 WAIT cycles, ir=32'h00000013, busy falls, fetch_done stays 0.
- Simultaneous fetch_start and pc_write (pc_source=0, pc=32'hFFFF_FFFC) -> pc=32'h0, and the REQ cycle shows imem_addr=32'h0.
- Assert RST during WAIT, then drive rvalid=1 with rdata=32'hDEADBEEF -> pc=RESET_VEC, ir=NOP, no fetch_done.
